// File: rtl/bcrypt_core_rx.sv
// Receives one bcrypt_core result packet over the 1-bit bus and hands out its words one at a time.
// Define BCRYPT_CORE_RX_TIMEOUT_EN to build the header-wait timeout and its sticky err flag.
//
// state  | meaning
// IDLE   | waiting for the core to report a pending result
// REQ    | one-cycle read request to the core
// HDR    | waiting for the 1'b1 header bit
// RECV   | shifting the packet into the word buffer, LSB-first
// OUT    | presenting buffered words to the downstream reader
module bcrypt_core_rx #(
    parameter int PKT_NWORDS     = 8,
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              core_empty,
    input  logic              core_dout,
    output logic              core_rd_en,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    input  logic              rd,
    output logic              busy,
    output logic              err
);

    localparam int PKT_BITS = PKT_NWORDS * WORD_W;
    localparam int CNT_W    = $clog2(PKT_BITS);
    localparam int IDX_W    = $clog2(PKT_NWORDS);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR, S_RECV, S_OUT} state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    bit_cnt;
    logic [IDX_W-1:0]    word_idx;
    logic [PKT_BITS-1:0] buf_q;
    logic                to_hit;

    assign core_rd_en = (state == S_REQ);
    assign busy       = (state != S_IDLE);

`ifdef BCRYPT_CORE_RX_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        err_q;

    assign to_hit = (state == S_HDR) && !core_dout && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign err    = err_q;

    // Counter is held at zero outside HDR, so every header wait starts fresh.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == S_HDR) ? to_cnt + 16'd1 : 16'd0;
            if (to_hit) err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign to_hit         = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (!core_empty) state_d = S_REQ;
            S_REQ:   state_d = S_HDR;
            S_HDR:   if (core_dout) state_d = S_RECV;
                     else if (to_hit) state_d = S_IDLE;
            S_RECV:  if (bit_cnt == CNT_W'(PKT_BITS - 1)) state_d = S_OUT;
            S_OUT:   if (dout_valid && rd && dout_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // First OUT cycle loads word 0; afterwards each accepted rd loads the next word directly.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            word_idx   <= '0;
            buf_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            case (state)
                S_RECV: begin
                    buf_q[bit_cnt] <= core_dout;
                    bit_cnt        <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(PKT_BITS - 1)) word_idx <= '0;
                end
                S_OUT: begin
                    if (!dout_valid) begin
                        dout       <= buf_q[word_idx*WORD_W +: WORD_W];
                        dout_valid <= 1'b1;
                        dout_last  <= (word_idx == IDX_W'(PKT_NWORDS - 1));
                    end else if (rd) begin
                        if (dout_last) begin
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                        end else begin
                            word_idx  <= word_idx + IDX_W'(1);
                            dout      <= buf_q[(int'(word_idx) + 1)*WORD_W +: WORD_W];
                            dout_last <= (word_idx == IDX_W'(PKT_NWORDS - 2));
                        end
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

endmodule
